// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory for the MEM stage with a request/acknowledge handshake,
// configurable access latency, sized loads/stores and rejection of illegal accesses.
module data_memory_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] data_o
);

    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q, ack_q, err_q;
    logic [31:0]   rdata_q;

    logic          we_q, unsigned_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, data_q;

    logic [7:0]    mem [DEPTH_BYTES];

    logic [AW-1:0] idx;
    logic [2:0]    nbytes;
    logic [32:0]   end_addr;
    logic          req_err_d;
    logic [31:0]   raw_d;
    logic          commit_d;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] res;
        case (size)
            2'b00:   res = uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   res = uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign idx = addr_q[AW-1:0];

    // The end address is formed in 33 bits so an access near 0xFFFFFFFF cannot wrap into range.
    always_comb begin
        case (size_q)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        end_addr  = {1'b0, addr_q} + {30'b0, nbytes};
        req_err_d = (size_q == 2'b11)
                  | ((size_q == 2'b01) && addr_q[0])
                  | ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
                  | (end_addr > 33'(DEPTH_BYTES));
        raw_d     = {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};
        commit_d  = (state_q == BUSY) && !req_err_d && (cnt_q == '0);
    end

    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && req_i) begin
            we_q       <= we_i;
            size_q     <= size_i;
            unsigned_q <= unsigned_i;
            addr_q     <= addr_i;
            data_q     <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit_d && we_q) begin
            mem[idx] <= data_q[7:0];
            if (size_q != 2'b00) begin
                mem[idx + AW'(1)] <= data_q[15:8];
            end
            if (size_q == 2'b10) begin
                mem[idx + AW'(2)] <= data_q[23:16];
                mem[idx + AW'(3)] <= data_q[31:24];
            end
        end
    end

    // Errors leave BUSY on the first edge; legal accesses wait for the counter to drain.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (req_i) begin
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (req_err_d) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= extend(raw_d, size_q, unsigned_q);
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign data_o = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a transaction-level memory model checked every cycle,
// plus literal expectations on each access.
module tb_data_memory_ctrl;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic        busy_o, ack_o, err_o;
    logic [31:0] data_o;

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .data_i(data_i),
        .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o), .data_o(data_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Transaction-level model: memory bytes plus edges remaining until the access completes.
    logic [7:0]  mmem [DEPTH];
    bit          m_inflight = 0;
    int          m_left = 0;
    bit          t_we, t_uns, t_err;
    logic [1:0]  t_sz;
    logic [31:0] t_a, t_d;
    logic        exp_busy = 0, exp_ack = 0, exp_err = 0;
    logic [31:0] exp_data = '0;

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit illegal(input logic [1:0] sz, input logic [31:0] a);
        longint last;
        last = longint'({32'b0, a}) + longint'(nbytes_of(sz));
        return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0)
               || (last > longint'(DEPTH));
    endfunction

    task automatic model_complete();
        int nb;
        logic [63:0] v;
        exp_ack = 1'b1;
        exp_err = t_err;
        nb = nbytes_of(t_sz);
        if (t_err) begin
            exp_data = '0;
        end else if (t_we) begin
            for (int i = 0; i < nb; i++) mmem[int'(t_a) + i] = t_d[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (64'(mmem[int'(t_a) + i]) << (8*i));
            if (!t_uns && nb < 4 && ((v >> (8*nb - 1)) & 64'd1) == 64'd1)
                v = v | ~((64'd1 << (8*nb)) - 64'd1);
            exp_data = v[31:0];
        end
    endtask

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_inflight = 0; m_left = 0;
            exp_busy = 0; exp_ack = 0; exp_err = 0; exp_data = '0;
        end else if (exp_ack) begin
            exp_ack = 0; exp_err = 0; exp_busy = 0; m_inflight = 0;
        end else if (m_inflight) begin
            m_left--;
            if (m_left == 0) model_complete();
        end else if (req_i) begin
            t_we = we_i; t_sz = size_i; t_uns = unsigned_i; t_a = addr_i; t_d = data_i;
            t_err = illegal(size_i, addr_i);
            m_left = t_err ? 1 : LAT;
            m_inflight = 1;
            exp_busy = 1;
        end
    end

    always @(negedge clk_i) begin
        if (check_en) begin
            chk("cyc busy", 32'(busy_o), 32'(exp_busy));
            chk("cyc ack",  32'(ack_o),  32'(exp_ack));
            chk("cyc err",  32'(err_o),  32'(exp_err));
            chk("cyc data", data_o, exp_data);
        end
    end

    task automatic do_op(input string name, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d,
                         input logic exp_e, input logic [31:0] exp_d);
        int lat;
        bit got;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; data_i = d;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0;
        got = 0; lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk_i); #1;
            if (ack_o) begin got = 1; lat = k; end
        end
        chk({name, " latency"}, 32'(lat), exp_e ? 32'd1 : 32'(LAT));
        chk({name, " err"}, 32'(err_o), 32'(exp_e));
        chk({name, " data"}, data_o, exp_d);
        @(posedge clk_i);
    endtask

    initial begin
        int acks;
        #3;
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst ack",  32'(ack_o),  32'd0);
        chk("rst err",  32'(err_o),  32'd0);
        chk("rst data", data_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        check_en = 1'b1;

        do_op("st w 10",   1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        do_op("ld w 10",   0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF);
        do_op("st b 11",   1, 2'b00, 0, 32'h11, 32'hFFFFFF80, 0, 32'hDEADBEEF);
        do_op("ld bs 11",  0, 2'b00, 0, 32'h11, 32'h0,        0, 32'hFFFFFF80);
        do_op("ld bu 11",  0, 2'b00, 1, 32'h11, 32'h0,        0, 32'h00000080);
        do_op("ld w 10b",  0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDEAD80EF);
        do_op("ld hs 10",  0, 2'b01, 0, 32'h10, 32'h0,        0, 32'hFFFF80EF);
        do_op("ld hu 10",  0, 2'b01, 1, 32'h10, 32'h0,        0, 32'h000080EF);
        do_op("st h 13",   1, 2'b01, 0, 32'h13, 32'h0000AAAA, 1, 32'h0);
        do_op("ld w 12",   0, 2'b10, 0, 32'h12, 32'h0,        1, 32'h0);
        do_op("ld w 10c",  0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDEAD80EF);
        do_op("ld sz11",   0, 2'b11, 0, 32'h10, 32'h0,        1, 32'h0);
        do_op("st w top",  1, 2'b10, 0, DEPTH - 4, 32'hCAFEF00D, 0, 32'h0);
        do_op("ld w top",  0, 2'b10, 0, DEPTH - 4, 32'h0,     0, 32'hCAFEF00D);
        do_op("ld w end",  0, 2'b10, 0, DEPTH,     32'h0,     1, 32'h0);
        do_op("ld w wrap", 0, 2'b10, 0, 32'hFFFFFFFC, 32'h0,  1, 32'h0);
        do_op("st w 20",   1, 2'b10, 0, 32'h20, 32'h0,        0, 32'h0);

        // request pulses during BUSY and DONE must not spawn extra accesses
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h10;
        @(posedge clk_i);
        acks = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            req_i = (k == 2 || k == 3);
            @(posedge clk_i); #1;
            if (ack_o) acks++;
        end
        chk("busy req acks", 32'(acks), 32'd1);
        chk("busy req data", data_o, 32'hDEAD80EF);

        // reset in the middle of a store must abandon it
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; addr_i = 32'h20; data_i = 32'h12345678;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        chk("midrst busy", 32'(busy_o), 32'd0);
        chk("midrst ack",  32'(ack_o),  32'd0);
        chk("midrst err",  32'(err_o),  32'd0);
        chk("midrst data", data_o, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        do_op("ld w 20", 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h0);

        repeat (2) @(negedge clk_i);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
